// File: rtl/rpn_stack_sequencer.sv
// RPN calculator sequencer: operand stack with push, and an
// operator path that hands the top two entries to a multi-cycle ALU.
module rpn_stack_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       Enter_pulse,
  input  logic                       Op_pulse,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [1:0]                 OpCode,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [1:0]                 alu_op,
  output logic                       alu_start,
  input  logic                       alu_done,
  input  logic [WIDTH-1:0]           alu_result,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       busy,
  output logic                       err,
  output logic [2:0]                 Status
);

  localparam int DW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ISSUE = 3'b001,
    WAIT  = 3'b010,
    ERR   = 3'b100
  } state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] stk [DEPTH];
  logic [WIDTH-1:0] below;
  logic             do_push, do_latch, do_wb, do_clr;

  // Top and second entry, selected by depth; zero when absent
  always_comb begin
    top   = '0;
    below = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(depth) == i + 1) top   = stk[i];
      if (int'(depth) == i + 2) below = stk[i];
    end
  end

  always_comb begin
    nxt       = state;
    do_push   = 1'b0;
    do_latch  = 1'b0;
    do_wb     = 1'b0;
    do_clr    = 1'b0;
    alu_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (Op_pulse) begin
          if (int'(depth) >= 2) begin
            do_latch = 1'b1;
            nxt      = ISSUE;
          end else begin
            nxt = ERR;
          end
        end else if (Enter_pulse) begin
          if (int'(depth) < DEPTH) do_push = 1'b1;
          else                     nxt     = ERR;
        end
      end
      ISSUE: begin
        alu_start = 1'b1;
        nxt       = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          do_wb = 1'b1;
          nxt   = IDLE;
        end
      end
      ERR: begin
        if (Enter_pulse) begin
          do_clr = 1'b1;
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state  <= IDLE;
      depth  <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      state <= nxt;
      if (do_latch) begin
        alu_a  <= below;
        alu_b  <= top;
        alu_op <= OpCode;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (do_clr)
          stk[i] <= '0;
        else if (do_push && int'(depth) == i)
          stk[i] <= data_in;
        else if (do_wb && int'(depth) == i + 2)
          stk[i] <= alu_result;
      end
      if (do_clr)       depth <= '0;
      else if (do_push) depth <= depth + DW'(1);
      else if (do_wb)   depth <= depth - DW'(1);
    end
  end

  assign busy   = (state == ISSUE) || (state == WAIT);
  assign err    = (state == ERR);
  assign Status = state;

endmodule

// File: doc/rpn_stack_sequencer.md
# rpn_stack_sequencer

Sequencer for the RPN calculator datapath: it owns a small operand stack, pushes operands on Enter, and on an operator command pops the top two entries, drives them through an external multi-cycle ALU over a start/done handshake, and pushes the result back. It replaces fixed A/B/opcode load sequencing with stack-based chaining (e.g. `5 3 + 2 *`). It sits between the debounced button pulses and the ALU/display path.

## Interface
- WIDTH, 16, operand/result width in bits
- DEPTH, 4, stack entries (≥2)
- clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Enter_pulse  in  1  one-cycle pulse: push data_in
- Op_pulse  in  1  one-cycle pulse: apply OpCode to top two entries
- data_in  in  WIDTH  operand to push
- OpCode  in  2  operation code forwarded to the ALU
- alu_a  out  WIDTH  first operand (entry below top), registered
- alu_b  out  WIDTH  second operand (top), registered
- alu_op  out  2  latched OpCode
- alu_start  out  1  one-cycle ALU start strobe
- alu_done  in  1  ALU result valid (one cycle)
- alu_result  in  WIDTH  ALU result
- top  out  WIDTH  current top of stack; 0 when empty
- depth  out  $clog2(DEPTH+1)  entries in use
- busy  out  1  high in ISSUE and WAIT
- err  out  1  high in ERR
- Status  out  3  state code for LEDs

## Operation
- States/Status: IDLE 000, ISSUE 001, WAIT 010, ERR 100. Unused encodings → IDLE.
- Reset: state IDLE, depth 0, all entries 0, alu_a/alu_b/alu_op 0, alu_start 0, err 0, busy 0, top 0, Status 000. Reset overrides any in-flight operation; a later alu_done from an aborted operation is ignored (arrives in IDLE).
- IDLE, Op_pulse:
  - depth ≥ 2: latch alu_a = entry[depth-2], alu_b = entry[depth-1], alu_op = OpCode; go to ISSUE.
  - depth < 2: go to ERR (underflow); stack unchanged.
- IDLE, Enter_pulse without Op_pulse:
  - depth < DEPTH: entry[depth] = data_in, depth+1.
  - depth = DEPTH: go to ERR (overflow); stack unchanged.
- Enter_pulse and Op_pulse in the same cycle: Op_pulse wins; Enter_pulse is dropped.
- ISSUE: alu_start = 1 for exactly this cycle; go to WAIT.
- WAIT: hold alu_a/alu_b/alu_op. On alu_done, write entry[depth-2] = alu_result, decrement depth, return to IDLE. No timeout; WAIT holds until alu_done or Reset.
- Pulses in ISSUE/WAIT are ignored (not queued).
- alu_done outside WAIT is ignored.
- ERR: err = 1 and stack is frozen. Enter_pulse clears the stack (depth 0, entries 0) and returns to IDLE; the data_in value is not pushed. Op_pulse is ignored.
- top = entry[depth-1] when depth > 0, else 0; combinational from registered state.
- Arithmetic is the ALU's job. alu_result is stored as is, WIDTH bits, with no width conversion.

## Timing
- Push: Enter_pulse sampled at edge k; depth and top are updated after edge k.
- Operator: Op_pulse at edge k → ISSUE during cycle k..k+1 (alu_start high). WAIT begins after edge k+1. alu_done sampled at edge m ≥ k+2 → top/depth updated and IDLE after edge m.
- Minimum operator turnaround with a 1-cycle ALU (alu_done at k+2): 3 cycles. The next pulse is accepted at edge k+3.
- alu_start never asserts for two consecutive cycles. busy = (state ∈ {ISSUE, WAIT}).
- Error entry: err and Status = 100 after the edge that samples the offending pulse.

## Test plan
- Push 5, push 3, Op_pulse with OpCode=00; ALU model returns a+b two cycles after alu_start → alu_a=5, alu_b=3, alu_op=00, one alu_start cycle, then top=8, depth=1, busy low.
- Chain: push 5, 3, +, push 2, Op with model a*b → top=16, depth=1. Also check the operand order for a−b: push 9, 4, a−b → top=5.
- Underflow: after reset, push 7, Op_pulse → err=1, Status=100, depth=1, no alu_start. Then Enter_pulse with data_in=1 → IDLE, depth=0, top=0.
- Overflow with DEPTH=4: push 1, 2, 3, 4, then push 5 → err=1, depth=4, top=4.
- Simultaneous: depth=2 (6, 2), assert Enter_pulse and Op_pulse in the same cycle with data_in=9 → operation issued; final depth=1, 9 never pushed. Pulses during WAIT are ignored.
- Reset mid-WAIT: assert Reset before alu_done, then an alu_done one cycle after Reset is released → all outputs at reset values, depth stays 0, no write.
